fetch_redirect_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage pipeline; consumes the branch/jump decision from the EX-stage branch detector (Do_branch, stall).
- Owns the PC register, the next-PC select and the IF/ID pipeline register.
- Squashes wrong-path instructions and drives the ID/EX flush.
- Honours the load-use hazard stall from the hazard unit.

---
 rtl/proc_pkg.sv | 28 ++
 rtl/fetch_redirect_unit_if.sv | 27 ++
 rtl/next_pc_sel.sv | 23 ++
 rtl/fetch_redirect_unit.sv | 87 ++++++++
 tb/tb_fetch_redirect_unit.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared fetch-stage types and constants: widths, NOP encoding, FSM states, next-PC selects.
package proc_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 32;

    localparam logic [INSTR_W-1:0] NOP     = '0;
    localparam logic [ADDR_W-1:0]  PC_STEP = ADDR_W'(4);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_HOLD   = 2'd3
    } npc_sel_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Fetch-stage bus: EX redirect inputs, hazard stall, instruction memory and IF/ID outputs.
interface fetch_redirect_unit_if;

    logic                           redirect;
    logic                           do_branch;
    logic [proc_pkg::ADDR_W-1:0]    branch_target;
    logic [proc_pkg::ADDR_W-1:0]    jump_target;
    logic                           hazard_stall;
    logic [proc_pkg::ADDR_W-1:0]    imem_addr;
    logic [proc_pkg::INSTR_W-1:0]   imem_rdata;
    logic [proc_pkg::ADDR_W-1:0]    ifid_pc;
    logic [proc_pkg::INSTR_W-1:0]   ifid_instr;
    logic                           ifid_valid;
    logic                           flush_idex;
    logic [proc_pkg::CNT_W-1:0]     squash_count;

    modport slave (
        input  redirect, do_branch, branch_target, jump_target, hazard_stall, imem_rdata,
        output imem_addr, ifid_pc, ifid_instr, ifid_valid, flush_idex, squash_count
    );

    modport master (
        output redirect, do_branch, branch_target, jump_target, hazard_stall, imem_rdata,
        input  imem_addr, ifid_pc, ifid_instr, ifid_valid, flush_idex, squash_count
    );

endinterface

// File: rtl/next_pc_sel.sv
// Next-PC mux: sequential step, aligned branch/jump target, or hold.
module next_pc_sel
    import proc_pkg::*;
(
    input  npc_sel_t            sel_i,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic [ADDR_W-1:0]   branch_target_i,
    input  logic [ADDR_W-1:0]   jump_target_i,
    output logic [ADDR_W-1:0]   next_pc_c_o
);

    always_comb begin
        next_pc_c_o = pc_i;
        unique case (sel_i)
            NPC_SEQ:    next_pc_c_o = pc_i + PC_STEP;
            NPC_BRANCH: next_pc_c_o = align_pc(branch_target_i);
            NPC_JUMP:   next_pc_c_o = align_pc(jump_target_i);
            NPC_HOLD:   next_pc_c_o = pc_i;
            default:    next_pc_c_o = pc_i;
        endcase
    end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch stage: PC register, IF/ID register, wrong-path squash and squash perf counter.
module fetch_redirect_unit
    import proc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fetch_redirect_unit_if.slave    fr_bus
);

    fetch_state_t           state_q;
    logic [ADDR_W-1:0]      pc_q;
    logic [ADDR_W-1:0]      pc_d;
    logic [ADDR_W-1:0]      ifid_pc_q;
    logic [INSTR_W-1:0]     ifid_instr_q;
    logic                   ifid_valid_q;
    logic [CNT_W-1:0]       squash_q;
    logic [CNT_W-1:0]       squash_d;
    logic [CNT_W:0]         squash_sum_c;
    logic [1:0]             squash_inc_c;
    npc_sel_t               sel_c;
    logic                   run_c;

    assign run_c = (state_q == RUN);

    // Redirect beats stall; BOOT holds the PC regardless of inputs.
    always_comb begin
        sel_c = NPC_HOLD;
        if (run_c) begin
            if (fr_bus.redirect) begin
                sel_c = fr_bus.do_branch ? NPC_BRANCH : NPC_JUMP;
            end else if (!fr_bus.hazard_stall) begin
                sel_c = NPC_SEQ;
            end
        end
    end

    next_pc_sel u_next_pc_sel (
        .sel_i           (sel_c),
        .pc_i            (pc_q),
        .branch_target_i (fr_bus.branch_target),
        .jump_target_i   (fr_bus.jump_target),
        .next_pc_c_o     (pc_d)
    );

    // The IF slot is always lost; the ID slot only counts when it held a real instruction.
    always_comb begin
        squash_inc_c = 2'd1 + 2'(ifid_valid_q);
        squash_sum_c = {1'b0, squash_q} + (CNT_W+1)'(squash_inc_c);
        squash_d     = squash_sum_c[CNT_W] ? {CNT_W{1'b1}} : squash_sum_c[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP;
            ifid_valid_q <= 1'b0;
            squash_q     <= '0;
        end else begin
            state_q <= RUN;
            pc_q    <= pc_d;
            if (run_c) begin
                if (fr_bus.redirect) begin
                    ifid_pc_q    <= '0;
                    ifid_instr_q <= NOP;
                    ifid_valid_q <= 1'b0;
                    squash_q     <= squash_d;
                end else if (!fr_bus.hazard_stall) begin
                    ifid_pc_q    <= pc_q;
                    ifid_instr_q <= fr_bus.imem_rdata;
                    ifid_valid_q <= 1'b1;
                end
            end
        end
    end

    assign fr_bus.imem_addr    = pc_q;
    assign fr_bus.ifid_pc      = ifid_pc_q;
    assign fr_bus.ifid_instr   = ifid_instr_q;
    assign fr_bus.ifid_valid   = ifid_valid_q;
    assign fr_bus.squash_count = squash_q;
    assign fr_bus.flush_idex   = fr_bus.redirect & run_c;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit; imem returns {8'hA5, addr[23:0]}.
module tb_fetch_redirect_unit;
    import proc_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fetch_redirect_unit_if bus ();

    fetch_redirect_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .fr_bus (bus)
    );

    assign bus.imem_rdata = {8'hA5, bus.imem_addr[23:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.redirect = 1'b1; bus.do_branch = 1'b1; bus.hazard_stall = 1'b0;
        bus.branch_target = 32'h0000_0500; bus.jump_target = 32'h0000_0600;
        #12;
        checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL reset_addr got %h exp %h", bus.imem_addr, 32'h100); end
        checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.ifid_valid); end
        checks++; if (bus.ifid_pc !== 32'h0) begin errors++; $display("FAIL reset_ifid_pc got %h exp 0", bus.ifid_pc); end
        checks++; if (bus.ifid_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", bus.ifid_instr); end
        checks++; if (bus.squash_count !== 32'h0) begin errors++; $display("FAIL reset_squash got %0d exp 0", bus.squash_count); end
        checks++; if (bus.flush_idex !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", bus.flush_idex); end
    endtask

    task automatic test_boot();
        tick();
        rst_n = 1'b1;
        bus.hazard_stall = 1'b1;
        #1;
        checks++; if (bus.flush_idex !== 1'b0) begin errors++; $display("FAIL boot_flush got %b exp 0", bus.flush_idex); end
        checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL boot_addr got %h exp %h", bus.imem_addr, 32'h100); end
        tick();
        bus.redirect = 1'b0; bus.hazard_stall = 1'b0;
        #1;
        checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL run0_addr got %h exp %h", bus.imem_addr, 32'h100); end
        checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL run0_valid got %b exp 0", bus.ifid_valid); end
        checks++; if (bus.squash_count !== 32'h0) begin errors++; $display("FAIL boot_squash got %0d exp 0", bus.squash_count); end
        tick();
        checks++; if (bus.imem_addr !== 32'h104) begin errors++; $display("FAIL run1_addr got %h exp %h", bus.imem_addr, 32'h104); end
        checks++; if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 32'h100) begin errors++; $display("FAIL run1_ifid got v=%b pc=%h exp v=1 pc=%h", bus.ifid_valid, bus.ifid_pc, 32'h100); end
        checks++; if (bus.ifid_instr !== 32'hA500_0100) begin errors++; $display("FAIL run1_instr got %h exp %h", bus.ifid_instr, 32'hA500_0100); end
        tick();
        checks++; if (bus.imem_addr !== 32'h108 || bus.ifid_pc !== 32'h104) begin errors++; $display("FAIL run2 got addr=%h pc=%h exp addr=%h pc=%h", bus.imem_addr, bus.ifid_pc, 32'h108, 32'h104); end
    endtask

    task automatic test_branch();
        bus.redirect = 1'b1; bus.do_branch = 1'b0;
        bus.jump_target = 32'h0000_001C; bus.branch_target = 32'hDEAD_0000;
        #1;
        checks++; if (bus.flush_idex !== 1'b1) begin errors++; $display("FAIL j1c_flush got %b exp 1", bus.flush_idex); end
        tick();
        bus.redirect = 1'b0;
        checks++; if (bus.imem_addr !== 32'h1C || bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL j1c_target got addr=%h v=%b exp addr=%h v=0", bus.imem_addr, bus.ifid_valid, 32'h1C); end
        checks++; if (bus.squash_count !== 32'd2) begin errors++; $display("FAIL j1c_squash got %0d exp 2", bus.squash_count); end
        tick();
        checks++; if (bus.imem_addr !== 32'h20 || bus.ifid_pc !== 32'h1C || bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL pre_br got addr=%h pc=%h v=%b exp 20/1c/1", bus.imem_addr, bus.ifid_pc, bus.ifid_valid); end
        bus.redirect = 1'b1; bus.do_branch = 1'b1;
        bus.branch_target = 32'h0000_0040; bus.jump_target = 32'h0000_0999;
        #1;
        checks++; if (bus.flush_idex !== 1'b1) begin errors++; $display("FAIL br_flush got %b exp 1", bus.flush_idex); end
        tick();
        bus.redirect = 1'b0;
        checks++; if (bus.imem_addr !== 32'h40) begin errors++; $display("FAIL br_target got %h exp %h", bus.imem_addr, 32'h40); end
        checks++; if (bus.ifid_valid !== 1'b0 || bus.ifid_pc !== 32'h0 || bus.ifid_instr !== 32'h0) begin errors++; $display("FAIL br_bubble got v=%b pc=%h i=%h exp 0/0/0", bus.ifid_valid, bus.ifid_pc, bus.ifid_instr); end
        checks++; if (bus.squash_count !== 32'd4) begin errors++; $display("FAIL br_squash got %0d exp 4", bus.squash_count); end
        tick();
        checks++; if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 32'h40 || bus.flush_idex !== 1'b0) begin errors++; $display("FAIL br_t2 got v=%b pc=%h f=%b exp 1/40/0", bus.ifid_valid, bus.ifid_pc, bus.flush_idex); end
    endtask

    task automatic test_jump_align();
        bus.redirect = 1'b1; bus.do_branch = 1'b0;
        bus.jump_target = 32'h0000_0083; bus.branch_target = 32'h0000_0200;
        tick();
        bus.redirect = 1'b0;
        checks++; if (bus.imem_addr !== 32'h80) begin errors++; $display("FAIL jalign_addr got %h exp %h", bus.imem_addr, 32'h80); end
        checks++; if (bus.squash_count !== 32'd6) begin errors++; $display("FAIL jalign_squash got %0d exp 6", bus.squash_count); end
    endtask

    task automatic test_hazard();
        bus.redirect = 1'b1; bus.do_branch = 1'b1; bus.branch_target = 32'h0000_0010;
        tick();
        bus.redirect = 1'b0; bus.hazard_stall = 1'b1;
        checks++; if (bus.squash_count !== 32'd7) begin errors++; $display("FAIL hz_pre_squash got %0d exp 7", bus.squash_count); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.imem_addr !== 32'h10 || bus.ifid_valid !== 1'b0 || bus.flush_idex !== 1'b0) begin errors++; $display("FAIL hz_hold%0d got addr=%h v=%b f=%b exp 10/0/0", i, bus.imem_addr, bus.ifid_valid, bus.flush_idex); end
        end
        bus.hazard_stall = 1'b0;
        tick();
        checks++; if (bus.imem_addr !== 32'h14 || bus.ifid_pc !== 32'h10 || bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL hz_resume got addr=%h pc=%h v=%b exp 14/10/1", bus.imem_addr, bus.ifid_pc, bus.ifid_valid); end
        bus.hazard_stall = 1'b1;
        tick();
        checks++; if (bus.imem_addr !== 32'h14 || bus.ifid_pc !== 32'h10 || bus.ifid_instr !== 32'hA500_0010) begin errors++; $display("FAIL hz_hold_valid got addr=%h pc=%h i=%h exp 14/10/a5000010", bus.imem_addr, bus.ifid_pc, bus.ifid_instr); end
        bus.hazard_stall = 1'b0;
        tick();
        checks++; if (bus.imem_addr !== 32'h18 || bus.ifid_pc !== 32'h14) begin errors++; $display("FAIL hz_after got addr=%h pc=%h exp 18/14", bus.imem_addr, bus.ifid_pc); end
        checks++; if (bus.squash_count !== 32'd7) begin errors++; $display("FAIL hz_squash got %0d exp 7", bus.squash_count); end
    endtask

    task automatic test_back_to_back();
        bus.redirect = 1'b1; bus.hazard_stall = 1'b1; bus.do_branch = 1'b1;
        bus.branch_target = 32'h0000_0300;
        #1;
        checks++; if (bus.flush_idex !== 1'b1) begin errors++; $display("FAIL b2b_flush0 got %b exp 1", bus.flush_idex); end
        tick();
        bus.hazard_stall = 1'b0; bus.do_branch = 1'b0; bus.jump_target = 32'h0000_0404;
        checks++; if (bus.imem_addr !== 32'h300 || bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL b2b_first got addr=%h v=%b exp 300/0", bus.imem_addr, bus.ifid_valid); end
        checks++; if (bus.squash_count !== 32'd9) begin errors++; $display("FAIL b2b_squash1 got %0d exp 9", bus.squash_count); end
        checks++; if (bus.flush_idex !== 1'b1) begin errors++; $display("FAIL b2b_flush1 got %b exp 1", bus.flush_idex); end
        tick();
        bus.redirect = 1'b0;
        checks++; if (bus.imem_addr !== 32'h404 || bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL b2b_second got addr=%h v=%b exp 404/0", bus.imem_addr, bus.ifid_valid); end
        checks++; if (bus.squash_count !== 32'd10) begin errors++; $display("FAIL b2b_squash2 got %0d exp 10", bus.squash_count); end
        tick();
        checks++; if (bus.imem_addr !== 32'h408 || bus.ifid_pc !== 32'h404 || bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL b2b_resume got addr=%h pc=%h v=%b exp 408/404/1", bus.imem_addr, bus.ifid_pc, bus.ifid_valid); end
    endtask

    task automatic test_wrap();
        bus.redirect = 1'b1; bus.do_branch = 1'b0; bus.jump_target = 32'hFFFF_FFFE;
        tick();
        bus.redirect = 1'b0; bus.do_branch = 1'b1; bus.branch_target = 32'h0000_0700;
        checks++; if (bus.imem_addr !== 32'hFFFF_FFFC || bus.squash_count !== 32'd12) begin errors++; $display("FAIL wrap_pre got addr=%h sq=%0d exp fffffffc/12", bus.imem_addr, bus.squash_count); end
        tick();
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", bus.imem_addr); end
        checks++; if (bus.ifid_pc !== 32'hFFFF_FFFC || bus.ifid_instr !== 32'hA5FF_FFFC) begin errors++; $display("FAIL wrap_ifid got pc=%h i=%h exp fffffffc/a5fffffc", bus.ifid_pc, bus.ifid_instr); end
    endtask

    task automatic test_reset_mid();
        bus.redirect = 1'b1; bus.do_branch = 1'b1; bus.branch_target = 32'h0000_0800;
        #1;
        checks++; if (bus.flush_idex !== 1'b1) begin errors++; $display("FAIL mid_flush_pre got %b exp 1", bus.flush_idex); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.imem_addr !== 32'h100 || bus.ifid_valid !== 1'b0 || bus.ifid_pc !== 32'h0) begin errors++; $display("FAIL mid_rst_ifid got addr=%h v=%b pc=%h exp 100/0/0", bus.imem_addr, bus.ifid_valid, bus.ifid_pc); end
        checks++; if (bus.squash_count !== 32'h0 || bus.flush_idex !== 1'b0) begin errors++; $display("FAIL mid_rst_cnt got sq=%0d f=%b exp 0/0", bus.squash_count, bus.flush_idex); end
        tick();
        checks++; if (bus.imem_addr !== 32'h100 || bus.ifid_instr !== 32'h0) begin errors++; $display("FAIL mid_rst_hold got addr=%h i=%h exp 100/0", bus.imem_addr, bus.ifid_instr); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_boot();
        test_branch();
        test_jump_align();
        test_hazard();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
